// File: rtl/anim_pkg.sv
// Shared constants and FSM state type for the LED animation frame store.
package anim_pkg;

  localparam int LED_WIDTH        = 16;
  localparam int FRAME_AW         = 5;
  localparam int FRAMES           = 32;
  localparam int DEBOUNCE_DEFAULT = 1000000;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_WRITE,
    ST_FULL
  } rec_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter, accepted level
// and a one-cycle pulse on each accepted press (release produces nothing).
module btn_debounce
  import anim_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic          level;
  logic [CW-1:0] cnt;

  // The counter only runs while the synced level disagrees with the accepted one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync  <= '0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      press <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync[1];
        press <= sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_recorder.sv
// Writer side of the LED frame store: captures switch patterns on debounced presses.
// Optional FRAME_RING_EN: captures while full overwrite the oldest frame in ring order.
module frame_recorder
  import anim_pkg::*;
#(
  parameter int WIDTH           = LED_WIDTH,
  parameter int FRAMES          = anim_pkg::FRAMES,
  parameter int AW              = FRAME_AW,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_pattern,
  input  logic             btn_capture,
  input  logic             btn_clear,
  input  logic [AW-1:0]    fm_no,
  output logic [WIDTH-1:0] frame,
  output logic [AW:0]      frame_count,
  output logic             full,
  output logic             busy,
  output logic             wr_ack
);

  localparam logic [AW-1:0] LAST_ADDR  = AW'(FRAMES - 1);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(FRAMES);

  rec_state_t       state;
  logic [WIDTH-1:0] sw_meta, sw_sync;
  logic             cap_ev, clr_ev;
  logic [AW-1:0]    wr_ptr, clr_ptr;
  logic [WIDTH-1:0] mem [FRAMES];
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_data;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cap_db (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_capture),
    .press (cap_ev)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_db (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_clear),
    .press (clr_ev)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw_pattern;
      sw_sync <= sw_meta;
    end
  end

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = wr_ptr;
    mem_data = sw_sync;
    case (state)
      ST_CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = clr_ptr;
        mem_data = '0;
      end
      ST_WRITE: mem_we = 1'b1;
`ifdef FRAME_RING_EN
      ST_FULL:  mem_we = cap_ev && !clr_ev;
`endif
      default:  mem_we = 1'b0;
    endcase
  end

  // Frame memory is deliberately unreset; the CLEAR sweep zeroes it.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_CLEAR;
      wr_ptr      <= '0;
      clr_ptr     <= '0;
      frame_count <= '0;
      full        <= 1'b0;
      busy        <= 1'b1;
      wr_ack      <= 1'b0;
      frame       <= '0;
    end else begin
      wr_ack <= 1'b0;
      frame  <= ({1'b0, fm_no} < frame_count) ? mem[fm_no] : '0;
      case (state)
        ST_CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == LAST_ADDR) begin
            frame_count <= '0;
            full        <= 1'b0;
            wr_ptr      <= '0;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (clr_ev) begin
            clr_ptr <= '0;
            busy    <= 1'b1;
            state   <= ST_CLEAR;
          end else if (cap_ev) begin
            state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          wr_ptr      <= wr_ptr + 1'b1;
          frame_count <= frame_count + 1'b1;
          wr_ack      <= 1'b1;
          if ((frame_count + 1'b1) == FULL_COUNT) begin
            full  <= 1'b1;
            state <= ST_FULL;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_FULL: begin
          if (clr_ev) begin
            clr_ptr <= '0;
            busy    <= 1'b1;
            state   <= ST_CLEAR;
          end
`ifdef FRAME_RING_EN
          else if (cap_ev) begin
            wr_ptr <= wr_ptr + 1'b1;
            wr_ack <= 1'b1;
          end
`endif
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_recorder.sv
// Randomized bench for frame_recorder against a frame-list reference model.
// Honours FRAME_RING_EN for the capture-while-full behaviour.
module tb_frame_recorder;

  localparam int FRAMES = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] sw_pattern = '0;
  logic        btn_capture = 1'b0;
  logic        btn_clear = 1'b0;
  logic [4:0]  fm_no = '0;
  logic [15:0] frame;
  logic [5:0]  frame_count;
  logic        full, busy, wr_ack;

  int n_cmp = 0;
  int n_err = 0;
  int ack_cnt = 0;

  logic [15:0] model_mem [FRAMES];
  int          model_count;
  int          model_ptr;

  frame_recorder #(.DEBOUNCE_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .sw_pattern  (sw_pattern),
    .btn_capture (btn_capture),
    .btn_clear   (btn_clear),
    .fm_no       (fm_no),
    .frame       (frame),
    .frame_count (frame_count),
    .full        (full),
    .busy        (busy),
    .wr_ack      (wr_ack)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst && wr_ack) ack_cnt++;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish (got timeout, expected completion)");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < FRAMES; i++) model_mem[i] = '0;
    model_count = 0;
    model_ptr   = 0;
  endtask

  // A full recorder either ignores captures or replaces the oldest frame.
  task automatic model_capture(input logic [15:0] p, output int exp_ack);
    exp_ack = 0;
    if (model_count < FRAMES) begin
      model_mem[model_ptr] = p;
      model_ptr   = (model_ptr + 1) % FRAMES;
      model_count = model_count + 1;
      exp_ack     = 1;
    end else begin
`ifdef FRAME_RING_EN
      model_mem[model_ptr] = p;
      model_ptr = (model_ptr + 1) % FRAMES;
      exp_ack   = 1;
`endif
    end
  endtask

  task automatic read_frame(input int k, output logic [15:0] v);
    fm_no = k[4:0];
    tick(1);
    v = frame;
  endtask

  task automatic press_capture(input logic [15:0] p, input int hold);
    sw_pattern = p;
    tick(3);
    btn_capture = 1'b1;
    tick(hold);
    btn_capture = 1'b0;
    tick(14);
  endtask

  task automatic press_clear();
    int n;
    btn_clear = 1'b1;
    tick(10);
    btn_clear = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 80) begin
      tick(1);
      n++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL clear_done: busy got %b expected 0", busy);
    end
    tick(10);
  endtask

  task automatic test_reset();
    int n;
    logic [15:0] v;
    rst = 1'b0;
    tick(2);
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL reset_busy: got %b expected 1", busy); end
    n_cmp++;
    if (frame_count !== 6'd0) begin n_err++; $display("[TB] FAIL reset_count: got %0d expected 0", frame_count); end
    n_cmp++;
    if (full !== 1'b0 || wr_ack !== 1'b0) begin n_err++; $display("[TB] FAIL reset_flags: got full=%b ack=%b expected 0/0", full, wr_ack); end
    n_cmp++;
    if (frame !== 16'h0) begin n_err++; $display("[TB] FAIL reset_frame: got %h expected 0000", frame); end
    rst = 1'b1;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (busy && n < 100);
    n_cmp++;
    if (n != 32) begin n_err++; $display("[TB] FAIL reset_sweep_len: got %0d cycles expected 32", n); end
    n_cmp++;
    if (frame_count !== 6'd0) begin n_err++; $display("[TB] FAIL post_sweep_count: got %0d expected 0", frame_count); end
    for (int i = 0; i < 3; i++) begin
      read_frame($urandom_range(0, 31), v);
      n_cmp++;
      if (v !== 16'h0) begin n_err++; $display("[TB] FAIL empty_read: got %h expected 0000", v); end
    end
    model_clear();
  endtask

  task automatic test_single_capture();
    int a0, e;
    logic [15:0] v;
    a0 = ack_cnt;
    model_capture(16'hA5A5, e);
    press_capture(16'hA5A5, 10);
    n_cmp++;
    if (ack_cnt - a0 != e) begin n_err++; $display("[TB] FAIL single_ack: got %0d expected %0d", ack_cnt - a0, e); end
    n_cmp++;
    if (frame_count !== 6'(model_count)) begin n_err++; $display("[TB] FAIL single_count: got %0d expected %0d", frame_count, model_count); end
    read_frame(0, v);
    n_cmp++;
    if (v !== 16'hA5A5) begin n_err++; $display("[TB] FAIL single_read0: got %h expected a5a5", v); end
    read_frame(1, v);
    n_cmp++;
    if (v !== 16'h0) begin n_err++; $display("[TB] FAIL single_read1: got %h expected 0000", v); end
  endtask

  task automatic test_glitch();
    int a0;
    a0 = ack_cnt;
    press_capture(16'($urandom), 2);
    n_cmp++;
    if (ack_cnt != a0) begin n_err++; $display("[TB] FAIL glitch_ack: got %0d expected 0", ack_cnt - a0); end
    n_cmp++;
    if (frame_count !== 6'(model_count)) begin n_err++; $display("[TB] FAIL glitch_count: got %0d expected %0d", frame_count, model_count); end
  endtask

  task automatic test_fill();
    int a0, e, exp_acks;
    logic [15:0] v, p;
    press_clear();
    model_clear();
    a0 = ack_cnt;
    exp_acks = 0;
    for (int k = 0; k < FRAMES; k++) begin
      model_capture(16'(k), e);
      exp_acks += e;
      press_capture(16'(k), 10);
    end
    n_cmp++;
    if (ack_cnt - a0 != exp_acks) begin n_err++; $display("[TB] FAIL fill_acks: got %0d expected %0d", ack_cnt - a0, exp_acks); end
    n_cmp++;
    if (full !== 1'b1 || frame_count !== 6'd32) begin n_err++; $display("[TB] FAIL fill_full: got full=%b count=%0d expected 1/32", full, frame_count); end
    for (int k = 0; k < FRAMES; k++) begin
      read_frame(k, v);
      n_cmp++;
      if (v !== model_mem[k]) begin n_err++; $display("[TB] FAIL fill_read[%0d]: got %h expected %h", k, v, model_mem[k]); end
    end
    p = 16'($urandom) | 16'h8000;
    a0 = ack_cnt;
    model_capture(p, e);
    press_capture(p, 10);
    n_cmp++;
    if (ack_cnt - a0 != e) begin n_err++; $display("[TB] FAIL extra_ack: got %0d expected %0d", ack_cnt - a0, e); end
    n_cmp++;
    if (full !== 1'b1 || frame_count !== 6'd32) begin n_err++; $display("[TB] FAIL extra_full: got full=%b count=%0d expected 1/32", full, frame_count); end
    for (int k = 0; k < 2; k++) begin
      read_frame(k, v);
      n_cmp++;
      if (v !== model_mem[k]) begin n_err++; $display("[TB] FAIL extra_read[%0d]: got %h expected %h", k, v, model_mem[k]); end
    end
  endtask

  task automatic test_random_ops();
    int a0, e, r, k;
    logic [15:0] v, p;
    press_clear();
    model_clear();
    for (int step = 0; step < 24; step++) begin
      r = $urandom_range(0, 9);
      p = 16'($urandom);
      a0 = ack_cnt;
      e = 0;
      if (r < 7) begin
        model_capture(p, e);
        press_capture(p, $urandom_range(8, 12));
      end else if (r < 9) begin
        press_capture(p, $urandom_range(1, 2));
      end else begin
        press_clear();
        model_clear();
      end
      n_cmp++;
      if (ack_cnt - a0 != e) begin n_err++; $display("[TB] FAIL rnd_ack[%0d]: got %0d expected %0d", step, ack_cnt - a0, e); end
      n_cmp++;
      if (frame_count !== 6'(model_count) || full !== (model_count == FRAMES)) begin
        n_err++;
        $display("[TB] FAIL rnd_count[%0d]: got %0d/%b expected %0d", step, frame_count, full, model_count);
      end
      k = $urandom_range(0, 31);
      read_frame(k, v);
      n_cmp++;
      if (v !== ((k < model_count) ? model_mem[k] : 16'h0)) begin
        n_err++;
        $display("[TB] FAIL rnd_read[%0d]: got %h expected %h", k, v, (k < model_count) ? model_mem[k] : 16'h0);
      end
    end
  endtask

  task automatic sweep_check(input string tag);
    int m, n;
    m = 0;
    while (busy !== 1'b1 && m < 30) begin
      tick(1);
      m++;
    end
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL %s_busy: got %b expected 1", tag, busy); end
    n = 0;
    while (busy && n < 100) begin
      tick(1);
      n++;
    end
    n_cmp++;
    if (n != 32) begin n_err++; $display("[TB] FAIL %s_sweep_len: got %0d expected 32", tag, n); end
  endtask

  task automatic test_simultaneous();
    int a0, e;
    logic [15:0] v;
    press_clear();
    model_clear();
    for (int i = 0; i < 3; i++) begin
      v = 16'($urandom) | 16'h0001;
      model_capture(v, e);
      press_capture(v, 10);
    end
    n_cmp++;
    if (frame_count !== 6'd3) begin n_err++; $display("[TB] FAIL simul_pre_count: got %0d expected 3", frame_count); end
    a0 = ack_cnt;
    btn_capture = 1'b1;
    btn_clear   = 1'b1;
    sweep_check("simul");
    btn_capture = 1'b0;
    btn_clear   = 1'b0;
    tick(14);
    model_clear();
    n_cmp++;
    if (ack_cnt != a0) begin n_err++; $display("[TB] FAIL simul_ack: got %0d expected 0", ack_cnt - a0); end
    n_cmp++;
    if (frame_count !== 6'd0 || full !== 1'b0) begin n_err++; $display("[TB] FAIL simul_count: got %0d/%b expected 0/0", frame_count, full); end
    for (int k = 0; k < 4; k++) begin
      read_frame(k, v);
      n_cmp++;
      if (v !== 16'h0) begin n_err++; $display("[TB] FAIL simul_read[%0d]: got %h expected 0000", k, v); end
    end
  endtask

  task automatic test_reset_mid_write();
    int a0, e;
    logic [15:0] v;
    press_clear();
    model_clear();
    for (int i = 0; i < 5; i++) begin
      v = 16'($urandom) | 16'h0100;
      model_capture(v, e);
      press_capture(v, 10);
    end
    n_cmp++;
    if (frame_count !== 6'd5) begin n_err++; $display("[TB] FAIL rstw_pre_count: got %0d expected 5", frame_count); end
    a0 = ack_cnt;
    sw_pattern = 16'hBEEF;
    tick(3);
    btn_capture = 1'b1;
    tick(7);
    rst = 1'b0;
    btn_capture = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b1 || frame_count !== 6'd0 || full !== 1'b0 || wr_ack !== 1'b0 || frame !== 16'h0) begin
      n_err++;
      $display("[TB] FAIL rstw_immediate: got busy=%b count=%0d full=%b ack=%b frame=%h expected 1/0/0/0/0000",
               busy, frame_count, full, wr_ack, frame);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    sweep_check("rstw");
    tick(10);
    model_clear();
    n_cmp++;
    if (ack_cnt != a0) begin n_err++; $display("[TB] FAIL rstw_ack: got %0d expected 0", ack_cnt - a0); end
    n_cmp++;
    if (frame_count !== 6'd0) begin n_err++; $display("[TB] FAIL rstw_count: got %0d expected 0", frame_count); end
    for (int k = 0; k < 6; k++) begin
      read_frame(k, v);
      n_cmp++;
      if (v !== 16'h0) begin n_err++; $display("[TB] FAIL rstw_read[%0d]: got %h expected 0000", k, v); end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single_capture();
    test_glitch();
    test_fill();
    test_random_ops();
    test_simultaneous();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
